fbg_payload_framer: RTL and testbench
=====================================

# fbg_payload_framer

Builds the UDP payload stream for one FBG spectrum frame and paces its transmission as a sequence of packets. It sits directly upstream of `eth_udp_tx_gmii`. It reads 16-bit samples from the `data_save` dual-port RAM read port, issues `tx_en_pulse` per packet, and serves bytes on `payload_req`. Each packet carries a 4-byte sequence header followed by {index, sample} records.

## Interface
- REC_PER_PKT, 300: records per packet.
- NUM_PKT, 6: packets per frame; total records = REC_PER_PKT*NUM_PKT (1800).
- RAM_AW, 11: RAM address width.
- RD_LAT, 1: RAM read latency in cycles, legal range 1..3.
- PKT_GAP, 31250: idle cycles between `tx_done` and the next packet's `tx_en_pulse`.

- clk125m  in  1  single clock, shared with `eth_udp_tx_gmii`.
- reset  in  1  synchronous, active-high.
- frame_start  in  1  one-cycle pulse that starts a frame; ignored while busy.
- tx_en_pulse  out  1  one-cycle packet start request to the UDP transmitter.
- tx_done  in  1  one-cycle pulse from the transmitter when the packet has finished.
- payload_req_i  in  1  byte consume strobe; the byte is taken in every cycle it is high.
- payload_dat_o  out  8  current payload byte.
- data_length  out  16  constant, 4 + 4*REC_PER_PKT (1204).
- ram_addr  out  RAM_AW  registered RAM read address.
- ram_dout  in  16  RAM read data, valid RD_LAT cycles after `ram_addr` changes.
- busy  out  1  high from accepted `frame_start` until `frame_done`.
- frame_done  out  1  one-cycle pulse after the last packet's gap expires.

## Operation
- **Packet layout**, byte order is exactly as transmitted:
  - Header: `seq`, `seq`, `seq`, `seq`, where `seq` = packet number 1..NUM_PKT.
  - Then per record: idx[7:0], idx[15:8], d[7:0], d[15:8].
  - `idx` runs 1..REC_PER_PKT*NUM_PKT continuously across packets (packet p carries idx (p-1)*REC_PER_PKT+1 .. p*REC_PER_PKT).
  - `d` = RAM word at address idx[RAM_AW-1:0].
- **FSM states**:
  - IDLE: on `frame_start` go to PREP with `seq`=1 and `idx`=1.
  - PREP: `ram_addr`<=idx; wait RD_LAT+1 cycles; latch `ram_dout` into the record register; go to REQ.
  - REQ: assert `tx_en_pulse` for one cycle; go to SEND.
  - SEND: serve bytes, one per `payload_req_i` cycle.
    - On the first byte of each record, set `ram_addr` to the next idx.
    - On consuming the record's last byte, latch `ram_dout` as the next record.
    - After the last record byte, go to WAIT_DONE.
  - WAIT_DONE: wait for `tx_done`; go to GAP.
  - GAP: count PKT_GAP cycles.
    - If `seq`<NUM_PKT: `seq`++ and go to PREP. The first record of the next packet is already latched, but PREP re-fetches it for simplicity.
    - Else: pulse `frame_done` and go to IDLE.
- **Byte counter**: 16-bit, cleared in REQ, incremented per `payload_req_i` while below `data_length`.
- **Boundary behaviour**:
  - `payload_req_i` after all `data_length` bytes: output 8'h00 and no advance.
  - `tx_done` received in SEND (early completion): abandon the remaining bytes and go to GAP. The next packet starts from the next packet's first idx; idx is recomputed from `seq`, not from the byte counter.
  - `payload_req_i` or `tx_done` in IDLE/PREP/REQ/GAP: ignored.
  - `frame_start` while `busy`: ignored; no queuing.
  - `reset` mid-frame: return to IDLE within the same clock edge; the frame is lost.

## Timing
- **Reset values**: `tx_en_pulse`=0, `frame_done`=0, `busy`=0, `ram_addr`=0, `payload_dat_o`=8'h00, state=IDLE. `data_length` is constant.
- **`payload_dat_o`**: a mux of registers only, with no combinational path from `payload_req_i`.
  - It holds header byte 0 from REQ until the first `payload_req_i`.
  - It shows byte n+1 in the cycle after the n-th `payload_req_i`, so back-to-back req cycles stream one byte per cycle.
  - Outside SEND/WAIT_DONE it reads 8'h00.
- **Start latency**: `frame_start` → `tx_en_pulse` is RD_LAT+3 cycles (1 cycle into PREP, RD_LAT+1 in PREP, 1 into REQ).
- **Packet spacing**: `tx_done` → next `tx_en_pulse` is PKT_GAP+RD_LAT+3 cycles.
- **`busy`**: rises the cycle after `frame_start` is accepted; falls together with `frame_done`.
- **RAM prefetch**: records take ≥4 req cycles, so RD_LAT≤3 always meets the prefetch deadline, even with continuous req.

## Test plan
- **Header and first record**: RAM[a]=a*3, `frame_start`, continuous req → packet 1 bytes 01 01 01 01 01 00 03 00 02 00 06 00…; 1204 bytes; last record idx 300 (2C 01 84 03).
- **Full frame**: NUM_PKT=6, model `tx_done` 10 cycles after the last req → 6 `tx_en_pulse`s with seq 1..6; packet 6 ends with idx 1800 (08 07); `frame_done` exactly once, then `busy`=0.
- **Gappy req**: req 1 cycle on / 2 off, RD_LAT=3 → byte stream identical to the continuous case.
- **Over-request and early done**:
  - 1210 req cycles → bytes 1205..1210 read 00.
  - A separate run with `tx_done` after byte 100 → next packet header 02 02 02 02, first idx 301.
- **Control corner cases**:
  - `frame_start` mid-frame is ignored; frame content unchanged.
  - `reset` asserted in SEND → next cycle state IDLE, all outputs at reset values; a following `frame_start` restarts at seq 1, idx 1.
- **Spacing**: PKT_GAP=100, RD_LAT=1 → `tx_done` to next `tx_en_pulse` = 104 cycles.

Source files
------------

// File: rtl/fbg_payload_framer.sv
// fbg_payload_framer: paces one FBG spectrum frame as NUM_PKT UDP payloads,
// each a 4-byte seq header followed by {idx, sample} records from sample RAM.
module fbg_payload_framer #(
  parameter int REC_PER_PKT = 300,
  parameter int NUM_PKT     = 6,
  parameter int RAM_AW      = 11,
  parameter int RD_LAT      = 1,
  parameter int PKT_GAP     = 31250
) (
  input  logic              clk125m,
  input  logic              reset,
  input  logic              frame_start,
  output logic              tx_en_pulse,
  input  logic              tx_done,
  input  logic              payload_req_i,
  output logic [7:0]        payload_dat_o,
  output logic [15:0]       data_length,
  output logic [RAM_AW-1:0] ram_addr,
  input  logic [15:0]       ram_dout,
  output logic              busy,
  output logic              frame_done
);

  localparam logic [15:0] DLEN     = 16'(4 + 4 * REC_PER_PKT);
  localparam logic [7:0]  LAST_SEQ = 8'(NUM_PKT);
  localparam int          CW       = $clog2(PKT_GAP + RD_LAT + 3);
  localparam logic [CW-1:0] PREP_END = CW'(RD_LAT + 1);
  localparam logic [CW-1:0] GAP_END  = CW'(PKT_GAP - 1);

  typedef enum logic [2:0] {
    IDLE, PREP, REQ, SEND, WAIT_DONE, GAP
  } state_t;

  state_t        state, nxt;
  logic [CW-1:0] cnt;
  logic [7:0]    seq;
  logic [15:0]   idx;
  logic [15:0]   smp;
  logic [15:0]   bcnt;
  logic [7:0]    rec_byte;
  logic          prep_end, gap_end, take, pkt_end, rec_end;

  assign data_length = DLEN;
  assign prep_end = (state == PREP) && (cnt == PREP_END);
  assign gap_end  = (state == GAP) && (cnt == GAP_END);
  assign take     = (state == SEND) && payload_req_i && !tx_done;
  assign pkt_end  = take && (bcnt == DLEN - 16'd1);
  assign rec_end  = take && (bcnt[1:0] == 2'd3) && (bcnt > 16'd4);

  always_ff @(posedge clk125m) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:      if (frame_start) nxt = PREP;
      PREP:      if (prep_end) nxt = REQ;
      REQ:       nxt = SEND;
      SEND: begin
        if (tx_done)      nxt = GAP;
        else if (pkt_end) nxt = WAIT_DONE;
      end
      WAIT_DONE: if (tx_done) nxt = GAP;
      GAP: begin
        if (gap_end) nxt = (seq < LAST_SEQ) ? PREP : IDLE;
      end
      default:   nxt = IDLE;
    endcase
  end

  // idx always names the record currently held in smp
  always_ff @(posedge clk125m) begin
    if (reset) begin
      cnt      <= '0;
      seq      <= 8'd0;
      idx      <= 16'd0;
      smp      <= 16'd0;
      bcnt     <= 16'd0;
      ram_addr <= '0;
    end else begin
      cnt <= (nxt != state) ? '0 : cnt + CW'(1);
      if (state == IDLE && frame_start) begin
        seq <= 8'd1;
        idx <= 16'd1;
      end
      if (state == PREP && cnt == '0) ram_addr <= RAM_AW'(idx);
      if (prep_end) begin
        smp      <= ram_dout;
        ram_addr <= RAM_AW'(idx + 16'd1);
      end
      if (state == REQ) bcnt <= 16'd0;
      if (take) bcnt <= bcnt + 16'd1;
      // next record lands as the current one finishes; fetch the one after
      if (rec_end) begin
        idx      <= idx + 16'd1;
        smp      <= ram_dout;
        ram_addr <= RAM_AW'(idx + 16'd2);
      end
      if (gap_end && seq < LAST_SEQ) begin
        seq <= seq + 8'd1;
        idx <= 16'(32'(seq) * REC_PER_PKT + 1);
      end
    end
  end

  always_comb begin
    rec_byte = 8'h00;
    unique case (1'b1)
      bcnt < 16'd4:  rec_byte = seq;
      bcnt >= DLEN:  rec_byte = 8'h00;
      default: begin
        case (bcnt[1:0])
          2'd0:    rec_byte = idx[7:0];
          2'd1:    rec_byte = idx[15:8];
          2'd2:    rec_byte = smp[7:0];
          default: rec_byte = smp[15:8];
        endcase
      end
    endcase
  end

  always_comb begin
    tx_en_pulse   = 1'b0;
    busy          = 1'b1;
    frame_done    = 1'b0;
    payload_dat_o = 8'h00;
    unique case (state)
      IDLE: busy = 1'b0;
      REQ: begin
        tx_en_pulse   = 1'b1;
        payload_dat_o = seq;
      end
      SEND, WAIT_DONE: payload_dat_o = rec_byte;
      GAP: frame_done = gap_end && (seq == LAST_SEQ);
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fbg_payload_framer.sv
// tb_fbg_payload_framer: drives frames through fbg_payload_framer with a
// latency-modelled RAM and compares every served byte to a packet model.
module tb_fbg_payload_framer;

  localparam int REC    = 300;
  localparam int NPKT   = 6;
  localparam int AW     = 11;
  localparam int RD_LAT = 3;
  localparam int GAP    = 100;
  localparam int DLEN   = 4 + 4 * REC;

  logic clk = 1'b0;
  always #4 clk = ~clk;

  logic          reset, frame_start, tx_done, req;
  logic          tx_en_pulse, busy, frame_done;
  logic [7:0]    payload_dat_o;
  logic [15:0]   data_length, ram_dout;
  logic [AW-1:0] ram_addr;

  logic [15:0] mem [2**AW];
  logic [15:0] q [RD_LAT];
  logic [7:0]  got [$];
  int pass_cnt = 0;
  int total_cnt = 0;
  int fd_cnt = 0;

  fbg_payload_framer #(
    .REC_PER_PKT(REC), .NUM_PKT(NPKT), .RAM_AW(AW),
    .RD_LAT(RD_LAT), .PKT_GAP(GAP)
  ) dut (
    .clk125m(clk), .reset(reset), .frame_start(frame_start),
    .tx_en_pulse(tx_en_pulse), .tx_done(tx_done),
    .payload_req_i(req), .payload_dat_o(payload_dat_o),
    .data_length(data_length), .ram_addr(ram_addr),
    .ram_dout(ram_dout), .busy(busy), .frame_done(frame_done)
  );

  // RAM: data for an address is sampleable RD_LAT+1 edges after it is set
  always @(posedge clk) begin
    q[0] <= mem[ram_addr];
    for (int i = 1; i < RD_LAT; i++) q[i] <= q[i-1];
  end
  assign ram_dout = q[RD_LAT-1];

  always @(posedge clk) if (frame_done === 1'b1) fd_cnt <= fd_cnt + 1;

  function automatic logic [7:0] exp_byte(int p, int n);
    int r;
    logic [15:0] id, d;
    if (n >= DLEN) return 8'h00;
    if (n < 4) return 8'(p);
    r  = (n - 4) / 4;
    id = 16'((p - 1) * REC + r + 1);
    d  = mem[id[AW-1:0]];
    case ((n - 4) % 4)
      0:       return id[7:0];
      1:       return id[15:8];
      2:       return d[7:0];
      default: return d[15:8];
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    tx_done = 1'b0;
  endtask

  task automatic wait_txen(output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (tx_en_pulse !== 1'b1 && cyc < GAP + RD_LAT + 60);
    if (tx_en_pulse !== 1'b1) cyc = -1;
  endtask

  // mode 0: continuous, 1: one on / two off, 2: random
  task automatic xfer(input int mode, input int nreq);
    int n, ph;
    logic on;
    got.delete();
    n = 0;
    ph = 0;
    while (n < nreq) begin
      tick();
      on = (mode == 0) ? 1'b1 :
           (mode == 1) ? (ph % 3 == 0) : ($urandom_range(0, 3) != 0);
      ph++;
      req = on;
      if (on) begin
        got.push_back(payload_dat_o);
        n++;
      end
    end
    tick();
    req = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    total_cnt++;
    if (tx_en_pulse !== 1'b0) $display("FAIL rst_txen: got %b want 0", tx_en_pulse);
    else pass_cnt++;
    total_cnt++;
    if (frame_done !== 1'b0) $display("FAIL rst_fdone: got %b want 0", frame_done);
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy);
    else pass_cnt++;
    total_cnt++;
    if (ram_addr !== '0) $display("FAIL rst_addr: got %h want 0", ram_addr);
    else pass_cnt++;
    total_cnt++;
    if (payload_dat_o !== 8'h00) $display("FAIL rst_dat: got %h want 00", payload_dat_o);
    else pass_cnt++;
    total_cnt++;
    if (data_length !== 16'd1204) $display("FAIL data_length: got %0d want 1204", data_length);
    else pass_cnt++;
    reset = 1'b0;
    req = 1'b1;
    tx_done = 1'b1;
    tick();
    tick();
    total_cnt++;
    if (busy !== 1'b0 || payload_dat_o !== 8'h00)
      $display("FAIL idle_ignore: busy %b dat %h want 0 00", busy, payload_dat_o);
    else pass_cnt++;
    req = 1'b0;
  endtask

  task automatic test_full_frame(input int mode);
    int cyc, bad, fd0;
    logic [7:0] hdr [12] = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h00,
                             8'h03, 8'h00, 8'h02, 8'h00, 8'h06, 8'h00};
    for (int a = 0; a < 2**AW; a++)
      mem[a] = (mode == 0) ? 16'(a * 3) : 16'($urandom);
    fd0 = fd_cnt;
    frame_start = 1'b1;
    wait_txen(cyc);
    total_cnt++;
    if (cyc != RD_LAT + 3) $display("FAIL m%0d_start_lat: got %0d want %0d", mode, cyc, RD_LAT + 3);
    else pass_cnt++;
    for (int p = 1; p <= NPKT; p++) begin
      if (p > 1) begin
        wait_txen(cyc);
        total_cnt++;
        if (cyc != GAP + RD_LAT + 3)
          $display("FAIL m%0d_spacing%0d: got %0d want %0d", mode, p, cyc, GAP + RD_LAT + 3);
        else pass_cnt++;
      end
      xfer(mode, DLEN);
      bad = -1;
      foreach (got[i]) if (bad < 0 && got[i] !== exp_byte(p, i)) bad = i;
      total_cnt++;
      if (bad >= 0)
        $display("FAIL m%0d_pkt%0d: byte %0d got %h want %h", mode, p, bad, got[bad], exp_byte(p, bad));
      else pass_cnt++;
      if (mode == 0 && p == 1) begin
        bad = -1;
        for (int i = 0; i < 12; i++) if (bad < 0 && got[i] !== hdr[i]) bad = i;
        total_cnt++;
        if (bad >= 0) $display("FAIL hdr_bytes: byte %0d got %h want %h", bad, got[bad], hdr[bad]);
        else pass_cnt++;
        total_cnt++;
        if ({got[1200], got[1201], got[1202], got[1203]} !== 32'h2C01_8403)
          $display("FAIL last_rec1: got %h%h%h%h want 2C018403", got[1200], got[1201], got[1202], got[1203]);
        else pass_cnt++;
      end
      if (mode == 0 && p == NPKT) begin
        total_cnt++;
        if ({got[1200], got[1201]} !== 16'h0807)
          $display("FAIL last_idx6: got %h%h want 0807", got[1200], got[1201]);
        else pass_cnt++;
      end
      repeat (9) tick();
      tx_done = 1'b1;
    end
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (frame_done !== 1'b1 && cyc < GAP + 50);
    total_cnt++;
    if (cyc != GAP) $display("FAIL m%0d_fdone_lat: got %0d want %0d", mode, cyc, GAP);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (busy !== 1'b0 || frame_done !== 1'b0)
      $display("FAIL m%0d_end_busy: busy %b fdone %b want 0 0", mode, busy, frame_done);
    else pass_cnt++;
    total_cnt++;
    if (fd_cnt - fd0 != 1) $display("FAIL m%0d_fdone_cnt: got %0d want 1", mode, fd_cnt - fd0);
    else pass_cnt++;
  endtask

  task automatic test_early_done();
    int cyc, bad;
    for (int a = 0; a < 2**AW; a++) mem[a] = 16'($urandom);
    frame_start = 1'b1;
    wait_txen(cyc);
    xfer(0, 100);
    tx_done = 1'b1;
    wait_txen(cyc);
    total_cnt++;
    if (cyc != GAP + RD_LAT + 3) $display("FAIL early_spacing: got %0d want %0d", cyc, GAP + RD_LAT + 3);
    else pass_cnt++;
    xfer(2, DLEN + 6);
    bad = -1;
    foreach (got[i]) if (bad < 0 && got[i] !== exp_byte(2, i)) bad = i;
    total_cnt++;
    if (bad >= 0) $display("FAIL early_pkt2: byte %0d got %h want %h", bad, got[bad], exp_byte(2, bad));
    else pass_cnt++;
    total_cnt++;
    if ({got[0], got[1], got[2], got[3], got[4], got[5]} !== 48'h0202_0202_2D01)
      $display("FAIL early_hdr_idx: got %h %h %h %h %h %h want 02 02 02 02 2D 01",
               got[0], got[1], got[2], got[3], got[4], got[5]);
    else pass_cnt++;
    bad = -1;
    for (int i = DLEN; i < DLEN + 6; i++) if (bad < 0 && got[i] !== 8'h00) bad = i;
    total_cnt++;
    if (bad >= 0) $display("FAIL over_req: byte %0d got %h want 00", bad, got[bad]);
    else pass_cnt++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_control();
    int cyc, bad;
    for (int a = 0; a < 2**AW; a++) mem[a] = 16'($urandom);
    frame_start = 1'b1;
    wait_txen(cyc);
    xfer(2, DLEN);
    tx_done = 1'b1;
    cyc = 0;
    do begin
      tick();
      cyc++;
      if (cyc == 20) frame_start = 1'b1;
    end while (tx_en_pulse !== 1'b1 && cyc < GAP + RD_LAT + 60);
    total_cnt++;
    if (cyc != GAP + RD_LAT + 3) $display("FAIL busy_start_spacing: got %0d want %0d", cyc, GAP + RD_LAT + 3);
    else pass_cnt++;
    xfer(2, 60);
    bad = -1;
    foreach (got[i]) if (bad < 0 && got[i] !== exp_byte(2, i)) bad = i;
    total_cnt++;
    if (bad >= 0) $display("FAIL busy_start_pkt2: byte %0d got %h want %h", bad, got[bad], exp_byte(2, bad));
    else pass_cnt++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total_cnt++;
    if ({tx_en_pulse, frame_done, busy} !== 3'b000 || ram_addr !== '0 || payload_dat_o !== 8'h00)
      $display("FAIL mid_reset: txen %b fdone %b busy %b addr %h dat %h want 0 0 0 0 00",
               tx_en_pulse, frame_done, busy, ram_addr, payload_dat_o);
    else pass_cnt++;
    tick();
    frame_start = 1'b1;
    wait_txen(cyc);
    total_cnt++;
    if (cyc != RD_LAT + 3) $display("FAIL restart_lat: got %0d want %0d", cyc, RD_LAT + 3);
    else pass_cnt++;
    xfer(1, DLEN);
    bad = -1;
    foreach (got[i]) if (bad < 0 && got[i] !== exp_byte(1, i)) bad = i;
    total_cnt++;
    if (bad >= 0) $display("FAIL restart_pkt1: byte %0d got %h want %h", bad, got[bad], exp_byte(1, bad));
    else pass_cnt++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    frame_start = 1'b0;
    tx_done = 1'b0;
    req = 1'b0;
    for (int a = 0; a < 2**AW; a++) mem[a] = 16'd0;
    test_reset();
    test_full_frame(0);
    test_full_frame(1);
    test_early_done();
    test_control();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
